// File: rtl/ntt_bank_scheduler.sv
// rtl/ntt_bank_scheduler.sv - in-place NTT stage sequencer for the coefficient banks
//
// Walks every bank address once per stage, then drains the write-back pipe so the
// next stage never reads a word the butterflies have not yet written.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   start      begin a transform (honoured only in IDLE)
//   busy       high while reading or draining
//   done       one-cycle completion pulse
//   stage      current stage index
//   ren        bank read enable; rd_addr / tw_idx valid with it
//   bfu_vld    bank Q valid for the butterflies (ren delayed one cycle)
//   wen        write-back enable; wr_addr is the read address delayed BFU_LAT+1
//   bank_en    bank EN = ren | wen
module ntt_bank_scheduler #(
  parameter int ADDR_W  = 7,
  parameter int STAGES  = 7,
  parameter int BFU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              ren,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              bfu_vld,
  output logic              wen,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              bank_en
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_K     = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAST_STAGE = 3'(STAGES - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  // pv[0] is the bfu_vld tap, pv[BFU_LAT] drives wen; pa carries the matching address.
  logic [BFU_LAT:0]  pv;
  logic [ADDR_W-1:0] pa [0:BFU_LAT];
  logic              drain_ok;

  // Twiddle stride shrinks each stage: index = k >> (ADDR_W - stage), zero at stage 0.
  function automatic logic [ADDR_W-1:0] tw_of(input logic [ADDR_W-1:0] kk,
                                              input logic [2:0] s);
    logic [31:0] sh;
    sh    = 32'(ADDR_W) - {29'd0, s};
    tw_of = kk >> sh;
  endfunction

  // Safe to start the next stage once no read is in flight ahead of the final pipe
  // slot; the write sitting in that slot is issued on the same edge.
  assign drain_ok = ~ren & ~(|pv[BFU_LAT-1:0]);

  assign bfu_vld = pv[0];
  assign wen     = pv[BFU_LAT];
  assign wr_addr = pa[BFU_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      stage   <= 3'd0;
      ren     <= 1'b0;
      rd_addr <= '0;
      tw_idx  <= '0;
      bank_en <= 1'b0;
      pv      <= '0;
      for (int i = 0; i <= BFU_LAT; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[BFU_LAT-1:0], ren};
      pa[0] <= rd_addr;
      for (int i = 1; i <= BFU_LAT; i++) pa[i] <= pa[i-1];

      // Default: no read next cycle; EN follows the write that moves into the last slot.
      ren     <= 1'b0;
      bank_en <= pv[BFU_LAT-1];

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            stage   <= 3'd0;
            rd_addr <= '0;
            tw_idx  <= '0;
            ren     <= 1'b1;
            bank_en <= 1'b1;
          end
        end
        READ: begin
          if (rd_addr == LAST_K) begin
            state   <= DRAIN;
            rd_addr <= '0;
            tw_idx  <= '0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
            tw_idx  <= tw_of(rd_addr + ADDR_W'(1), stage);
            ren     <= 1'b1;
            bank_en <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            if (stage < LAST_STAGE) begin
              state   <= READ;
              stage   <= stage + 3'd1;
              rd_addr <= '0;
              tw_idx  <= '0;
              ren     <= 1'b1;
              bank_en <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_bank_scheduler.sv
// tb/tb_ntt_bank_scheduler.sv - scoreboard bench for ntt_bank_scheduler
module tb_ntt_bank_scheduler;

  localparam int AW = 7, ST = 7, LAT = 4, DEPTH = 128, P = DEPTH + LAT + 1;
  localparam int AW2 = 3, ST2 = 1, LAT2 = 1, DEPTH2 = 8, P2 = DEPTH2 + LAT2 + 1;

  typedef struct { int cyc; int stg; int addr; int tw; } rd_t;
  typedef struct { int cyc; int addr; } wr_t;

  logic clk = 1'b0;
  logic rst, start, start2;
  int   cyc = 0;
  int   nchk = 0, nfail = 0;
  bit   mon_en = 1'b0;
  logic rst_at_edge = 1'b1;

  logic          busy, done, ren, bfu_vld, wen, bank_en;
  logic [2:0]    stage;
  logic [AW-1:0] rd_addr, tw_idx, wr_addr;

  logic           busy2, done2, ren2, bfu_vld2, wen2, bank_en2;
  logic [2:0]     stage2;
  logic [AW2-1:0] rd_addr2, tw_idx2, wr_addr2;

  rd_t rd_q[$], rd2_q[$];
  wr_t wr_q[$], wr2_q[$];
  int  done_q[$], done2_q[$];

  ntt_bank_scheduler #(.ADDR_W(AW), .STAGES(ST), .BFU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
    .ren(ren), .rd_addr(rd_addr), .tw_idx(tw_idx), .bfu_vld(bfu_vld), .wen(wen),
    .wr_addr(wr_addr), .bank_en(bank_en));

  ntt_bank_scheduler #(.ADDR_W(AW2), .STAGES(ST2), .BFU_LAT(LAT2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .stage(stage2),
    .ren(ren2), .rd_addr(rd_addr2), .tw_idx(tw_idx2), .bfu_vld(bfu_vld2), .wen(wen2),
    .wr_addr(wr_addr2), .bank_en(bank_en2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int tw_ref(input int k, input int s, input int aw);
    return k >> (aw - s);
  endfunction

  task automatic push_tf(input int c);
    for (int s = 0; s < ST; s++)
      for (int k = 0; k < DEPTH; k++) begin
        rd_q.push_back('{c + 1 + P*s + k, s, k, tw_ref(k, s, AW)});
        wr_q.push_back('{c + 1 + P*s + k + LAT + 1, k});
      end
    done_q.push_back(c + P*ST + 1);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Main instance monitor
  bit prev_ren = 1'b0;
  always @(negedge clk) if (mon_en) begin
    rd_t r; wr_t w; int d;
    if (ren) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_cycle", cyc, r.cyc);
        chk("rd_addr", int'(rd_addr), r.addr);
        chk("tw_idx", int'(tw_idx), r.tw);
        chk("rd_stage", int'(stage), r.stg);
      end
    end
    if (wen) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr", int'(wr_addr), w.addr);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
      end
    end
    chk("bank_en", int'(bank_en), int'(ren | wen));
    if (!rst_at_edge) chk("bfu_vld", int'(bfu_vld), int'(prev_ren));
    prev_ren = ren;
  end

  // Small-parameter instance monitor
  bit prev_ren2 = 1'b0;
  always @(negedge clk) if (mon_en) begin
    rd_t r; wr_t w; int d;
    if (ren2) begin
      if (rd2_q.size() == 0) chk("rd2_unexpected", 1, 0);
      else begin
        r = rd2_q.pop_front();
        chk("rd2_cycle", cyc, r.cyc);
        chk("rd2_addr", int'(rd_addr2), r.addr);
        chk("tw2_idx", int'(tw_idx2), r.tw);
      end
    end
    if (wen2) begin
      if (wr2_q.size() == 0) chk("wr2_unexpected", 1, 0);
      else begin
        w = wr2_q.pop_front();
        chk("wr2_cycle", cyc, w.cyc);
        chk("wr2_addr", int'(wr_addr2), w.addr);
      end
    end
    if (done2) begin
      if (done2_q.size() == 0) chk("done2_unexpected", 1, 0);
      else begin
        d = done2_q.pop_front();
        chk("done2_cycle", cyc, d);
      end
    end
    chk("bank_en2", int'(bank_en2), int'(ren2 | wen2));
    if (!rst_at_edge) chk("bfu_vld2", int'(bfu_vld2), int'(prev_ren2));
    prev_ren2 = ren2;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ren"}, int'(ren), 0);
    chk({tag, "_wen"}, int'(wen), 0);
    chk({tag, "_bfu_vld"}, int'(bfu_vld), 0);
    chk({tag, "_bank_en"}, int'(bank_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_tw_idx"}, int'(tw_idx), 0);
    chk({tag, "_stage"}, int'(stage), 0);
  endtask

  initial begin
    int t0, s2, s3;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_ren2", int'(ren2), 0);
    chk("reset_wen2", int'(wen2), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Transform 1 on both instances; small instance: reads 1-8, writes 3-10, done 11.
    t0 = 10;
    push_tf(t0);
    for (int k = 0; k < DEPTH2; k++) begin
      rd2_q.push_back('{t0 + 1 + k, 0, k, tw_ref(k, 0, AW2)});
      wr2_q.push_back('{t0 + 1 + k + LAT2 + 1, k});
    end
    done2_q.push_back(t0 + P2*ST2 + 1);

    wait_cyc(t0);
    chk("idle_busy", int'(busy), 0);
    start = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    chk("busy_first", int'(busy), 1);

    // Starts during busy must be ignored
    wait_cyc(t0 + 50);  start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(t0 + 500); start = 1'b1; @(negedge clk); start = 1'b0;

    wait_cyc(t0 + 931);
    chk("busy_last", int'(busy), 1);
    wait_cyc(t0 + 932);
    chk("busy_in_done", int'(busy), 0);
    chk("done_pulse", int'(done), 1);
    // Held through DONE (ignored) into the next IDLE cycle (accepted)
    s2 = t0 + 933;
    for (int k = 0; k < 70; k++) rd_q.push_back('{s2 + 1 + k, 0, k, 0});
    for (int k = 0; k <= 64; k++) wr_q.push_back('{s2 + 1 + k + LAT + 1, k});
    start = 1'b1;
    @(negedge clk);
    chk("done_cleared", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);

    // Reset mid stage 0 with writes in flight
    wait_cyc(s2 + 70);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");

    s3 = s2 + 80;
    push_tf(s3);
    wait_cyc(s3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    wait_cyc(s3 + P*ST + 5);
    chk("idle_after", int'(busy), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("rd2_q_empty", rd2_q.size(), 0);
    chk("wr2_q_empty", wr2_q.size(), 0);
    chk("done2_q_empty", done2_q.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
